// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - load-use hazard, bypass select and PC/decode enable control
//
// Tracks register writes in flight across DEPTH post-decode stages
// (0 = EX, 1 = MEM, 2 = WB). From that scoreboard and the decode-stage
// fields it produces the PC/decode enables, the EX bubble and the bypass
// select for each register-file read port.
//
// Build option: HAZARD_FWD_EN
//   defined   - results are bypassed; only loads younger than LOAD_STAGE stall
//   undefined - no bypassing; any pending write to a source stalls decode
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   id_valid               decode stage holds a real instruction
//   id_rj, id_rk           source registers
//   id_uses_j, id_uses_k   the corresponding source is actually read
//   id_rd, id_we, id_load  destination register, write enable, memory load
//   flush                  kill the decode-stage instruction
//   p_enable, i_enable     PC advance / decode register load
//   bubble                 insert a NOP into EX this cycle
//   fwd_sel_j, fwd_sel_k   0 = register file, n = result of stage n-1
//   stall_cnt              saturating count of stall cycles
module pipe_hazard_unit #(
    parameter int REG_SIZE   = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_SIZE   = 16,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_SIZE-1:0] id_rj,
    input  logic [REG_SIZE-1:0] id_rk,
    input  logic                id_uses_j,
    input  logic                id_uses_k,
    input  logic [REG_SIZE-1:0] id_rd,
    input  logic                id_we,
    input  logic                id_load,
    input  logic                flush,
    output logic                p_enable,
    output logic                i_enable,
    output logic                bubble,
    output logic [SEL_W-1:0]    fwd_sel_j,
    output logic [SEL_W-1:0]    fwd_sel_k,
    output logic [CNT_SIZE-1:0] stall_cnt
);

    logic [DEPTH-1:0]    ent_v;
    logic [DEPTH-1:0]    ent_ld;
    logic [REG_SIZE-1:0] ent_rd [DEPTH];

    logic             hit_j, hit_k;
    logic             ld_j, ld_k;
    logic [SEL_W-1:0] n_j, n_k;
    logic             stall;

    // Walk from oldest to youngest so the youngest match is the one that
    // sticks; an older entry can never mask a younger producer.
    always_comb begin
        hit_j = 1'b0;
        hit_k = 1'b0;
        ld_j  = 1'b0;
        ld_k  = 1'b0;
        n_j   = '0;
        n_k   = '0;
        for (int n = DEPTH - 1; n >= 0; n--) begin
            if (ent_v[n] && id_uses_j && (id_rj != '0) && (ent_rd[n] == id_rj)) begin
                hit_j = 1'b1;
                ld_j  = ent_ld[n];
                n_j   = SEL_W'(n);
            end
            if (ent_v[n] && id_uses_k && (id_rk != '0) && (ent_rd[n] == id_rk)) begin
                hit_k = 1'b1;
                ld_k  = ent_ld[n];
                n_k   = SEL_W'(n);
            end
        end
    end

`ifdef HAZARD_FWD_EN
    localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_STAGE);

    // Load data is not available before LOAD_STAGE; a younger load blocks.
    logic blk_j, blk_k;
    assign blk_j     = hit_j & ld_j & (n_j < LOAD_SEL);
    assign blk_k     = hit_k & ld_k & (n_k < LOAD_SEL);
    assign stall     = id_valid & ~flush & (blk_j | blk_k);
    assign fwd_sel_j = hit_j ? n_j + SEL_W'(1) : '0;
    assign fwd_sel_k = hit_k ? n_k + SEL_W'(1) : '0;
`else
    localparam int unused_load_stage = LOAD_STAGE;

    // Without bypassing, decode waits until the producer leaves the last
    // tracked stage; the register file then supplies the value.
    logic unused_fwd;
    assign unused_fwd = ^{ld_j, ld_k, n_j, n_k};
    assign stall      = id_valid & ~flush & (hit_j | hit_k);
    assign fwd_sel_j  = '0;
    assign fwd_sel_k  = '0;
`endif

    assign p_enable = ~stall;
    assign i_enable = ~stall;
    assign bubble   = stall | flush;

    // A stalled or flushed decode instruction does not move into EX, so an
    // invalid entry is shifted in behind the producers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v  <= '0;
            ent_ld <= '0;
            for (int n = 0; n < DEPTH; n++) begin
                ent_rd[n] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int n = DEPTH - 1; n > 0; n--) begin
                ent_v[n]  <= ent_v[n-1];
                ent_ld[n] <= ent_ld[n-1];
                ent_rd[n] <= ent_rd[n-1];
            end
            ent_v[0]  <= id_valid & id_we & (id_rd != '0) & ~stall & ~flush;
            ent_ld[0] <= id_load;
            ent_rd[0] <= id_rd;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_SIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - scoreboard bench for pipe_hazard_unit (both HAZARD_FWD_EN builds)
module tb_pipe_hazard_unit;

    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid, id_uses_j, id_uses_k, id_we, id_load, flush;
    logic [4:0]      id_rj, id_rk, id_rd;
    logic            p_enable, i_enable, bubble;
    logic [1:0]      fwd_sel_j, fwd_sel_k;
    logic [CW-1:0]   stall_cnt;

    pipe_hazard_unit #(.CNT_SIZE(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rj(id_rj), .id_rk(id_rk),
        .id_uses_j(id_uses_j), .id_uses_k(id_uses_k),
        .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .flush(flush),
        .p_enable(p_enable), .i_enable(i_enable), .bubble(bubble),
        .fwd_sel_j(fwd_sel_j), .fwd_sel_k(fwd_sel_k), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pen;
        logic          bub;
        logic [1:0]    fj;
        logic [1:0]    fk;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic pen, input logic bub, input logic [1:0] fj, input logic [1:0] fk);
        exp_t e;
        e.pen = pen; e.bub = bub; e.fj = fj; e.fk = fk; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("p_enable",  p_enable,  e.pen);
        check("i_enable",  i_enable,  e.pen);
        check("bubble",    bubble,    e.bub);
        check("fwd_sel_j", fwd_sel_j, e.fj);
        check("fwd_sel_k", fwd_sel_k, e.fk);
        check("stall_cnt", stall_cnt, e.cnt);
    endtask

    // One decode cycle: drive, sample at the falling edge, then clock it in.
    task automatic cyc(input logic v, input logic [4:0] rj, input logic uj,
                       input logic [4:0] rk, input logic uk, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl,
                       input logic e_pen, input logic e_bub,
                       input logic [1:0] e_fj, input logic [1:0] e_fk);
        id_valid = v; id_rj = rj; id_uses_j = uj; id_rk = rk; id_uses_k = uk;
        id_rd = rd; id_we = we; id_load = ld; flush = fl;
        push_exp(e_pen, e_bub, e_fj, e_fk);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        if (!e_pen && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        #1;
    endtask

    task automatic do_write(input logic [4:0] rd, input logic ld);
        cyc(1, 0, 0, 0, 0, rd, 1, ld, 0, 1, 0, 0, 0);
    endtask

    task automatic do_read_j(input logic [4:0] rj, input logic pen, input logic [1:0] fj);
        cyc(1, rj, 1, 0, 0, 0, 0, 0, 0, pen, ~pen, fj, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    // Caller has just clocked a producer of rj into EX; check the stall,
    // then pull reset mid-cycle and check everything clears at once.
    task automatic reset_during_stall(input logic [4:0] rj, input logic [1:0] stall_fj);
        id_valid = 1; id_rj = rj; id_uses_j = 1; id_rk = 0; id_uses_k = 0;
        id_rd = 0; id_we = 0; id_load = 0; flush = 0;
        push_exp(0, 1, stall_fj, 0);
        #2;
        pop_check();
        rst_n = 0;
        exp_cnt = '0;
        #1;
        push_exp(1, 0, 0, 0);
        pop_check();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        do_read_j(rj, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        id_valid = 0; id_rj = 0; id_rk = 0; id_uses_j = 0; id_uses_k = 0;
        id_rd = 0; id_we = 0; id_load = 0; flush = 0;
        #3;
        push_exp(1, 0, 0, 0);
        pop_check();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

`ifdef HAZARD_FWD_EN
        do_write(3, 0);
        do_read_j(3, 1, 1);
        do_read_j(3, 1, 2);
        do_write(5, 1);
        cyc(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 2);
        do_write(0, 0);
        do_write(4, 0);
        do_write(4, 0);
        cyc(1, 4, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        do_write(6, 1);
        cyc(1, 6, 1, 0, 0, 9, 1, 0, 1, 1, 1, 1, 0);
        cyc(1, 9, 1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 2);
        do_write(8, 1);
        reset_during_stall(8, 1);
        for (int r = 0; r < 9; r++) begin
            do_write(12, 1);
            do_read_j(12, 0, 1);
            do_read_j(12, 1, 2);
        end
        idle();
`else
        do_write(7, 0);
        do_read_j(7, 0, 0);
        do_read_j(7, 0, 0);
        do_read_j(7, 0, 0);
        do_read_j(7, 1, 0);
        do_write(2, 0);
        cyc(1, 2, 1, 0, 0, 9, 1, 0, 1, 1, 1, 0, 0);
        cyc(1, 9, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 9, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 9, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        do_write(0, 0);
        do_read_j(0, 1, 0);
        do_write(11, 0);
        reset_during_stall(11, 0);
        for (int r = 0; r < 3; r++) begin
            do_write(12, 0);
            for (int c = 0; c < 4; c++) begin
                do_read_j(12, (c == 3), 0);
            end
        end
        idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and bypass controller for the five-stage pipeline, replacing the fixed single-register bypass control. It tracks in-flight register writes across a configurable number of post-decode stages and drives the PC/decode-register enables. It also selects the forwarding source for both register-file read ports and inserts bubbles on load-use hazards. It sits beside the decode stage: decode-stage fields go in, and enables, bubble and forwarding selects come out.

## Interface
Parameters:
- REG_SIZE, 5, register index width.
- DEPTH, 3, tracked stages after decode (index 0 = EX, 1 = MEM, 2 = WB).
- LOAD_STAGE, 1, first stage index at which load data can be forwarded; legal range is 1..DEPTH-1.
- CNT_SIZE, 16, width of the stall counter.
- SEL_W, $clog2(DEPTH+1), width of the forwarding selects.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rj  in  REG_SIZE  first source register.
- id_rk  in  REG_SIZE  second source register.
- id_uses_j, id_uses_k  in  1 each  the source is actually read.
- id_rd  in  REG_SIZE  destination register.
- id_we  in  1  instruction writes id_rd.
- id_load  in  1  instruction is a memory load.
- flush  in  1  kill the decode-stage instruction.
- p_enable  out  1  PC register advance.
- i_enable  out  1  decode register load.
- bubble  out  1  issue a NOP into the EX stage this cycle.
- fwd_sel_j, fwd_sel_k  out  SEL_W each  0 = register file, n = stage n-1 result.
- stall_cnt  out  CNT_SIZE  saturating count of stall cycles.

## Operation
- Scoreboard: DEPTH entries {v, rd, ld}. Every clock, entry[n] <= entry[n-1].
- Entry[0] <= {id_valid & id_we & (id_rd != 0) & ~stall & ~flush, id_rd, id_load}. A stall or flush therefore shifts in an invalid entry.
- Match at stage n for source s: entry[n].v & uses_s & entry[n].rd == s. Register 0 never matches.
- Forwarding (HAZARD_FWD_EN defined):
  - A match at n with ~ld, or with ld and n >= LOAD_STAGE, is forwardable.
  - fwd_sel_s = n+1, where n is the lowest-index (youngest) matching stage. With no match, fwd_sel_s = 0.
  - stall = id_valid & ~flush & (some source's youngest match is a load with n < LOAD_STAGE).
- Priority: the youngest match decides. An older forwardable match never hides a younger unforwardable one.
- Outputs: p_enable = i_enable = ~stall. bubble = stall | flush.
- stall_cnt increments on every cycle with stall = 1 and saturates at all-ones.
- With flush = 1, stall is forced to 0 and the PC and decode register advance. The flushed instruction is not recorded.
- All outputs except stall_cnt are combinational from the scoreboard and the id_* inputs.

## Timing
- Reset (asynchronous, any cycle, including mid-stall):
  - Every entry becomes invalid.
  - stall_cnt = 0.
  - Outputs immediately read p_enable = 1, i_enable = 1, bubble = 0, fwd_sel_j = fwd_sel_k = 0, unless id_* inputs are already active.
- Stall duration: a load in EX followed by a dependent instruction stalls for LOAD_STAGE cycles. The bubbles advance the load until it reaches LOAD_STAGE.
- A write in stage DEPTH-1 is visible as a forwarding source for one cycle, then leaves the scoreboard. The register file covers it from then on, because it writes in the first half of the cycle.
- Flush and stall in the same cycle: flush wins. Exactly one bubble is issued and stall_cnt does not increment.
- stall_cnt at saturation stays at all-ones.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described above.
- HAZARD_FWD_EN undefined:
  - fwd_sel_j and fwd_sel_k are tied to 0.
  - Any match in any stage asserts stall, and the stall lasts until the producing entry leaves stage DEPTH-1.
  - LOAD_STAGE is ignored.

## Test plan
- Reset, then ALU write to r3 followed by a read of r3 (defaults, forwarding on): fwd_sel_j = 1, stall = 0. One cycle later, a read of r3 gives fwd_sel_j = 2.
- Load to r5, then an immediate read of r5: exactly one cycle with p_enable = 0 and bubble = 1, then fwd_sel = 2. stall_cnt = 1.
- Writes to r4 in EX and MEM both present, then a read of r4: fwd_sel = 1 (youngest). A read of r0 with a pending r0 write gives fwd_sel = 0.
- Load-use hazard coinciding with flush = 1: no stall, bubble = 1, stall_cnt unchanged. The next cycle's entry[0] is invalid.
- Forwarding disabled (HAZARD_FWD_EN undefined), ALU write to r7 then a read of r7: 3 stall cycles (DEPTH = 3), then a register-file read with fwd_sel = 0.
- rst_n pulsed low during a stall: stall clears asynchronously, stall_cnt = 0, and all entries are invalid on release.
